pi_ctrl: RTL

Parametrised priority-interrupt controller for the KS10 CPU, successor to the fixed 7-level PI logic. It holds channel enables, software requests and the in-progress ("held") levels, and arbitrates external bus requests against them. It presents a single interrupt request plus the winning level to the microcontroller's skip and dispatch logic, and sits between the bus request lines and the `interrupt_req`/`pi_new` inputs of the CPU.

---
 rtl/pi_pkg.sv | 21 ++
 rtl/pi_prio_enc.sv | 26 ++
 rtl/pi_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pi_pkg.sv
// Shared definitions for the priority-interrupt controller: command opcodes
// and the level-number width helper.
package pi_pkg;

  typedef enum logic [2:0] {
    PI_NOP     = 3'd0,
    PI_SET_EN  = 3'd1,
    PI_CLR_EN  = 3'd2,
    PI_SET_SW  = 3'd3,
    PI_CLR_SW  = 3'd4,
    PI_SYS_ON  = 3'd5,
    PI_SYS_OFF = 3'd6,
    PI_CLEAR   = 3'd7
  } pi_op_e;

  // Level numbers are 1-based with 0 meaning "none", hence NLEV+1 codes.
  function automatic int pi_lvlw(input int nlev);
    return $clog2(nlev + 1);
  endfunction

endpackage

// File: rtl/pi_prio_enc.sv
// Lowest-set-bit encoder: returns the 1-based index of the highest-priority
// (lowest-indexed) active level, 0 with o_valid low when the vector is empty.
module pi_prio_enc
  import pi_pkg::*;
#(
  parameter int NLEV = 7,
  localparam int LVLW = pi_lvlw(NLEV)
) (
  input  logic [NLEV-1:0] i_vec,
  output logic [LVLW-1:0] o_idx,
  output logic            o_valid
);

  // Scan from the top down so the last hit wins, i.e. the lowest index.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = NLEV - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = LVLW'(i + 1);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pi_ctrl.sv
// Priority-interrupt controller: channel enables, software requests and held
// levels, arbitrated against registered bus requests into one CPU request.
module pi_ctrl
  import pi_pkg::*;
#(
  parameter int NLEV = 7,
  parameter int LVLW = pi_lvlw(NLEV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clken,
  input  logic            cmd_valid,
  input  logic [2:0]      cmd_op,
  input  logic [NLEV-1:0] cmd_mask,
  input  logic [NLEV-1:0] bus_req,
  input  logic            ack,
  input  logic            dismiss,
  output logic            pi_on,
  output logic [NLEV-1:0] pi_en,
  output logic [NLEV-1:0] pi_sw,
  output logic [NLEV-1:0] pi_held,
  output logic            intr_req,
  output logic [LVLW-1:0] pi_new,
  output logic [LVLW-1:0] pi_cur
);

  logic            r_on;
  logic [NLEV-1:0] r_en;
  logic [NLEV-1:0] r_sw;
  logic [NLEV-1:0] r_held;
  logic [NLEV-1:0] r_req;

  logic [NLEV-1:0] w_pend;
  logic [NLEV-1:0] w_pend_low;
  logic [LVLW-1:0] w_lvl_l;
  logic [LVLW-1:0] w_lvl_h;
  logic            w_pend_v;
  logic            w_held_v;
  logic            w_intr;
  logic            w_accept;
  logic            w_clear;

  logic            w_on_nx;
  logic [NLEV-1:0] w_en_nx;
  logic [NLEV-1:0] w_sw_nx;
  logic [NLEV-1:0] w_held_nx;

  // Software requests bypass the channel enables.
  assign w_pend = r_on ? ((r_req & r_en) | r_sw) : '0;

  pi_prio_enc #(.NLEV(NLEV)) u_enc_pend (
    .i_vec   (w_pend),
    .o_idx   (w_lvl_l),
    .o_valid (w_pend_v)
  );

  pi_prio_enc #(.NLEV(NLEV)) u_enc_held (
    .i_vec   (r_held),
    .o_idx   (w_lvl_h),
    .o_valid (w_held_v)
  );

  // Only a strictly higher priority (smaller number) may interrupt.
  assign w_intr     = w_pend_v && (!w_held_v || (w_lvl_l < w_lvl_h));
  assign w_accept   = ack && w_intr;
  assign w_pend_low = w_pend & (~w_pend + NLEV'(1));

  always_comb begin
    w_on_nx   = r_on;
    w_en_nx   = r_en;
    w_sw_nx   = r_sw;
    w_held_nx = r_held;
    w_clear   = 1'b0;

    if (cmd_valid) begin
      case (cmd_op)
        PI_SET_EN:  w_en_nx = r_en | cmd_mask;
        PI_CLR_EN:  w_en_nx = r_en & ~cmd_mask;
        PI_SET_SW:  w_sw_nx = r_sw | cmd_mask;
        PI_CLR_SW:  w_sw_nx = r_sw & ~cmd_mask;
        PI_SYS_ON:  w_on_nx = 1'b1;
        PI_SYS_OFF: w_on_nx = 1'b0;
        PI_CLEAR: begin
          w_on_nx   = 1'b0;
          w_en_nx   = '0;
          w_sw_nx   = '0;
          w_held_nx = '0;
          w_clear   = 1'b1;
        end
        default: ;
      endcase
    end

    // Dismiss drops the lowest set bit of held; a no-op when nothing is held.
    if (dismiss) begin
      w_held_nx = w_held_nx & (w_held_nx - NLEV'(1));
    end

    // Ack uses the level presented before the edge; CLEAR wins over it.
    if (w_accept && !w_clear) begin
      w_held_nx = w_held_nx | w_pend_low;
      w_sw_nx   = w_sw_nx & ~w_pend_low;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_on   <= 1'b0;
      r_en   <= '0;
      r_sw   <= '0;
      r_held <= '0;
      r_req  <= '0;
    end else if (clken) begin
      r_on   <= w_on_nx;
      r_en   <= w_en_nx;
      r_sw   <= w_sw_nx;
      r_held <= w_held_nx;
      r_req  <= bus_req;
    end
  end

  assign pi_on    = r_on;
  assign pi_en    = r_en;
  assign pi_sw    = r_sw;
  assign pi_held  = r_held;
  assign intr_req = w_intr;
  assign pi_new   = w_intr ? w_lvl_l : '0;
  assign pi_cur   = w_lvl_h;

endmodule
